regfile_dump_reader: RTL and testbench

Read-side initiator for the 32x32 register file. On a start pulse it walks an inclusive address range through one register-file read port and streams each word out over a valid/ready interface. The stream goes to a UART/LED debug display path. The block only reads; it never drives the register-file write port.

---
 rtl/regfile_dump_reader.sv | 101 ++++++++++
 tb/tb_regfile_dump_reader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Read-side initiator for the register file: walks an inclusive, wrapping address
// range through one read port and streams each word out over valid/ready.
module regfile_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [ADDR_W-1:0] last_q;

    // The read port follows cur in every state, so the address never glitches.
    assign rf_addr = cur;

    // NOTE: every state register uses <= so all updates see the pre-edge values.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            cur       <= '0;
            last_q    <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // start outranks abort here; abort only affects an active walk
                    if (start) begin
                        cur    <= first_addr;
                        last_q <= last_addr;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end

                FETCH: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        out_data  <= rf_data;
                        out_addr  <= cur;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (abort) begin
                        // A pending word is dropped even if it would handshake now.
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cur == last_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cur   <= cur + ADDR_W'(1);
                            state <= FETCH;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: table of dump ranges plus hand-written
// abort and asynchronous-reset sequences, against a local register-file array.
module tb_regfile_dump_reader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rf [32];
    assign rf_data = rf[rf_addr];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .start      (start),
        .abort      (abort),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         exp_n;   // words expected
        int         stall;   // cycles of out_ready=0 on the first word
        int         inj;     // loop cycle for an ignored start, -1 for none
        bit         poke;    // write reg 9 while reg 8 is in SEND
        bit         abrt;    // raise abort together with start in IDLE
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a, input bit poked);
        if (poked && a == 5'd9) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(a);
    endfunction

    task automatic do_dump(input vec_t v);
        int         n;
        int         stall_left;
        bit         in_word;
        bit         accepted;
        bit         got_done;
        logic [4:0] exp_a;
        logic [4:0] cap_addr;
        logic [31:0] cap_data;
        @(negedge clk);
        first_addr = v.first;
        last_addr  = v.last;
        start      = 1'b1;
        abort      = v.abrt;
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("fetch_busy", 32'(busy), 32'd1);
        check("fetch_valid", 32'(out_valid), 32'd0);
        check("fetch_rf_addr", 32'(rf_addr), 32'(v.first));
        n = 0; stall_left = v.stall; in_word = 0; accepted = 0; got_done = 0;
        cap_addr = '0; cap_data = '0;
        for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
            @(negedge clk);
            if (cyc == v.inj) begin
                start      = 1'b1;
                first_addr = v.first + 5'd3;
                last_addr  = v.first + 5'd4;
            end else begin
                start = 1'b0;
            end
            if (accepted) check("gap_after_handshake", 32'(out_valid), 32'd0);
            if (done) begin
                got_done = 1;
                check("done_after_last_hs", 32'(accepted), 32'd1);
                check("done_busy", 32'(busy), 32'd0);
            end else if (out_valid) begin
                if (!in_word) begin
                    if (n == 0) check("first_valid_latency", 32'(cyc), 32'd0);
                    exp_a = 5'(32'(v.first) + n);
                    check("word_addr", 32'(out_addr), 32'(exp_a));
                    check("word_data", out_data, exp_data(exp_a, v.poke));
                    check("word_busy", 32'(busy), 32'd1);
                    cap_addr = out_addr;
                    cap_data = out_data;
                    in_word  = 1;
                    if (v.poke && exp_a == 5'd8) rf[9] = 32'hDEAD_BEEF;
                end else begin
                    check("stall_addr_stable", 32'(out_addr), 32'(cap_addr));
                    check("stall_data_stable", out_data, cap_data);
                    check("stall_valid_busy", 32'(busy), 32'd1);
                end
            end
            accepted = 0;
            if (out_valid && stall_left > 0 && n == 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    n++;
                    in_word  = 0;
                    accepted = 1;
                end
            end
        end
        start = 1'b0;
        check("dump_done_seen", 32'(got_done), 32'd1);
        check("word_count", 32'(n), 32'(v.exp_n));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_valid", 32'(out_valid), 32'd0);
    endtask

    vec_t vecs [6];

    initial begin
        bit found;
        vecs[0] = '{first: 5'd3,  last: 5'd5,  exp_n: 3,  stall: 0, inj: -1, poke: 0, abrt: 0};
        vecs[1] = '{first: 5'd30, last: 5'd1,  exp_n: 4,  stall: 0, inj: -1, poke: 0, abrt: 0};
        vecs[2] = '{first: 5'd3,  last: 5'd5,  exp_n: 3,  stall: 5, inj: -1, poke: 0, abrt: 0};
        vecs[3] = '{first: 5'd0,  last: 5'd31, exp_n: 32, stall: 0, inj: 10, poke: 0, abrt: 0};
        vecs[4] = '{first: 5'd7,  last: 5'd7,  exp_n: 1,  stall: 0, inj: -1, poke: 0, abrt: 0};
        vecs[5] = '{first: 5'd5,  last: 5'd4,  exp_n: 32, stall: 2, inj: 3,  poke: 0, abrt: 0};

        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        reset_ = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_out_addr", 32'(out_addr), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset_ = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) do_dump(vecs[i]);

        // Abort while the second word is in SEND, with out_ready high the same cycle.
        @(negedge clk);
        first_addr = 5'd10; last_addr = 5'd15; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (out_valid && out_addr == 5'd11) begin
                found = 1;
                abort = 1'b1;
                out_ready = 1'b1;
            end
        end
        check("abort_reached_word2", 32'(found), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        do_dump('{first: 5'd0, last: 5'd0, exp_n: 1, stall: 0, inj: -1, poke: 0, abrt: 1});

        // Asynchronous reset in SEND; outputs must clear before any clock edge.
        @(negedge clk);
        first_addr = 5'd3; last_addr = 5'd5; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_in_send", 32'(out_valid), 32'd1);
        #2 reset_ = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_addr", 32'(out_addr), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        check("async_rst_rf_addr", 32'(rf_addr), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_idle_busy", 32'(busy), 32'd0);
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
            check("post_rst_no_done", 32'(done), 32'd0);
        end
        do_dump('{first: 5'd8, last: 5'd10, exp_n: 3, stall: 1, inj: -1, poke: 1, abrt: 0});
        rf[9] = 32'h1000_0009;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
